// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 raster constants and framebuffer geometry.
package vga_pkg;

  typedef logic [9:0] cnt_t;

  localparam cnt_t H_ACTIVE = 10'd640;
  localparam cnt_t H_FP     = 10'd16;
  localparam cnt_t H_SYNC   = 10'd96;
  localparam cnt_t H_BP     = 10'd48;
  localparam cnt_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam cnt_t V_ACTIVE = 10'd480;
  localparam cnt_t V_FP     = 10'd10;
  localparam cnt_t V_SYNC   = 10'd2;
  localparam cnt_t V_BP     = 10'd33;
  localparam cnt_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_SYNC_START = H_ACTIVE + H_FP;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam cnt_t V_SYNC_START = V_ACTIVE + V_FP;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Framebuffer geometry, shared with the filler.
  localparam int unsigned FB_W = 160;
  localparam int unsigned FB_H = 120;

endpackage

// File: rtl/fb_scanout_if.sv
// Scanout bus: framebuffer read port plus the VGA DAC pins.
interface fb_scanout_if #(
  parameter int unsigned ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  pixel_in;
  logic                  hsync;
  logic                  vsync;
  logic [3:0]            vga_r;
  logic [3:0]            vga_g;
  logic [3:0]            vga_b;
  logic                  vblank;

  modport master (
    output read_addr,
    input  pixel_in,
    output hsync,
    output vsync,
    output vga_r,
    output vga_g,
    output vga_b,
    output vblank
  );

  modport slave (
    input  read_addr,
    output pixel_in,
    input  hsync,
    input  vsync,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vblank
  );
endinterface

// File: rtl/vga_timing.sv
// Raster counters and raw (unaligned) timing decode for 640x480@60.
module vga_timing
  import vga_pkg::*;
(
  input  logic clk_25,
  input  logic reset_n,
  output cnt_t h_cnt_o,
  output cnt_t v_cnt_o,
  output logic active_o,
  output logic hsync_n_o,
  output logic vsync_n_o,
  output logic vblank_o
);

  cnt_t h_q;
  cnt_t v_q;

  // Raster counters: h wraps every line, v advances only on the h wrap.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_TOTAL - 10'd1) begin
      h_q <= '0;
      v_q <= (v_q == V_TOTAL - 10'd1) ? '0 : v_q + 10'd1;
    end else begin
      h_q <= h_q + 10'd1;
    end
  end

  // Timing decode straight from the counters; the top aligns it with RAM data.
  always_comb begin
    h_cnt_o   = h_q;
    v_cnt_o   = v_q;
    active_o  = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
    hsync_n_o = ~((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
    vsync_n_o = ~((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
    vblank_o  = (v_q >= V_ACTIVE);
  end

endmodule

// File: rtl/fb_scanout.sv
// QQVGA 1 bpp framebuffer scanout: 4x upscale onto 640x480@60 VGA pins.
module fb_scanout
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned FB_W       = vga_pkg::FB_W,
  parameter int unsigned FB_H       = vga_pkg::FB_H,
  parameter logic [11:0] FG_RGB     = 12'hFFF
) (
  input  logic         clk_25,
  input  logic         reset_n,
  fb_scanout_if.master bus
);

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic active;
  logic hsync_n;
  logic vsync_n;
  logic vblank_raw;

  vga_timing u_timing (
    .clk_25    (clk_25),
    .reset_n   (reset_n),
    .h_cnt_o   (h_cnt),
    .v_cnt_o   (v_cnt),
    .active_o  (active),
    .hsync_n_o (hsync_n),
    .vsync_n_o (vsync_n),
    .vblank_o  (vblank_raw)
  );

  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] col;

  // Stage 0: row*160 as two shifts; blanked positions park on address 0.
  always_comb begin
    row           = ADDR_WIDTH'(v_cnt >> 2);
    col           = ADDR_WIDTH'(h_cnt >> 2);
    bus.read_addr = active ? (row << 7) + (row << 5) + col : '0;
  end

  logic active_q1;
  logic hsync_q1;
  logic vsync_q1;
  logic vblank_q1;

  // Stage 1: delay timing by the RAM's one-cycle read latency.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      active_q1 <= 1'b0;
      hsync_q1  <= 1'b1;
      vsync_q1  <= 1'b1;
      vblank_q1 <= 1'b0;
    end else begin
      active_q1 <= active;
      hsync_q1  <= hsync_n;
      vsync_q1  <= vsync_n;
      vblank_q1 <= vblank_raw;
    end
  end

  logic [11:0] rgb_q;
  logic        hsync_q2;
  logic        vsync_q2;
  logic        vblank_q2;

  // Stage 2: colour map (pixel masked outside active) and register onto the pins.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q     <= '0;
      hsync_q2  <= 1'b1;
      vsync_q2  <= 1'b1;
      vblank_q2 <= 1'b0;
    end else begin
      rgb_q     <= (active_q1 && bus.pixel_in) ? FG_RGB : 12'h000;
      hsync_q2  <= hsync_q1;
      vsync_q2  <= vsync_q1;
      vblank_q2 <= vblank_q1;
    end
  end

  // Pin drive.
  always_comb begin
    {bus.vga_r, bus.vga_g, bus.vga_b} = rgb_q;
    bus.hsync  = hsync_q2;
    bus.vsync  = vsync_q2;
    bus.vblank = vblank_q2;
  end

  // The address can never leave the framebuffer.
  assert property (@(posedge clk_25) disable iff (!reset_n)
    bus.read_addr < ADDR_WIDTH'(FB_W * FB_H));

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: sync-read RAM model, raster reference model, scoreboard.
module tb_fb_scanout;
  localparam int unsigned AW = 15;
  localparam logic [11:0] FG = 12'hFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fb_scanout_if #(.ADDR_WIDTH(AW)) bus ();

  fb_scanout #(
    .ADDR_WIDTH (AW),
    .FB_W       (160),
    .FB_H       (120),
    .FG_RGB     (FG)
  ) dut (
    .clk_25  (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  bit          mem [0:19199];
  bit          force_one = 1'b0;
  int          checks = 0;
  int          passed = 0;
  int unsigned cyc = 0;
  int unsigned rel_cyc = 0;
  int          mh = 0;
  int          mv = 0;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vb;
  } exp_t;

  exp_t sb[$];

  initial forever #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer RAM: one-cycle synchronous read.
  always @(posedge clk)
    bus.pixel_in <= force_one ? 1'b1 :
                    ((bus.read_addr < AW'(19200)) ? mem[bus.read_addr] : 1'b0);

  // Reference raster position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh <= 0;
      mv <= 0;
    end else if (mh == 799) begin
      mh <= 0;
      mv <= (mv == 524) ? 0 : mv + 1;
    end else begin
      mh <= mh + 1;
    end
  end

  function automatic exp_t model_at(input int h, input int v);
    exp_t e;
    bit   act;
    act   = (h < 640) && (v < 480);
    e.h   = h;
    e.v   = v;
    e.rgb = 12'h000;
    if (act && (force_one || mem[(v / 4) * 160 + h / 4])) e.rgb = FG;
    e.hs  = !(h >= 656 && h < 752);
    e.vs  = !(v >= 490 && v < 492);
    e.vb  = (v >= 480);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.h = -1; e.v = -1; e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.vb = 1'b0;
    return e;
  endfunction

  // Scoreboard: expectation for each position, compared two cycles later at the pins.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst_n) begin
      sb.delete();
      sb.push_back(reset_exp());
      sb.push_back(model_at(0, 0));
    end else begin
      sb.push_back(model_at(mh, mv));
      if (sb.size() > 2) begin
        e = sb.pop_front();
        checks++;
        if ({bus.vga_r, bus.vga_g, bus.vga_b, bus.hsync, bus.vsync, bus.vblank} !==
            {e.rgb, e.hs, e.vs, e.vb})
          $display("FAIL scoreboard h=%0d v=%0d got rgb=%h hs=%b vs=%b vb=%b want rgb=%h hs=%b vs=%b vb=%b",
                   e.h, e.v, {bus.vga_r, bus.vga_g, bus.vga_b}, bus.hsync, bus.vsync,
                   bus.vblank, e.rgb, e.hs, e.vs, e.vb);
        else passed++;
      end
    end
  end

  task automatic wait_for(input int sel, input logic lvl, input int unsigned bound,
                          output bit ok);
    logic s;
    ok = 1'b0;
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      s = (sel == 0) ? bus.hsync : (sel == 1) ? bus.vsync : bus.vblank;
      if (s === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pos(input int h, input int v, input int unsigned bound, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      if (mh == h && mv == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.hsync, bus.vsync} !== 2'b11)
      $display("FAIL reset_sync got %b want 11", {bus.hsync, bus.vsync});
    else passed++;
    checks++;
    if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h000)
      $display("FAIL reset_rgb got %h want 000", {bus.vga_r, bus.vga_g, bus.vga_b});
    else passed++;
    checks++;
    if (bus.read_addr !== '0) $display("FAIL reset_addr got %0d want 0", bus.read_addr);
    else passed++;
    checks++;
    if (bus.vblank !== 1'b0) $display("FAIL reset_vblank got %b want 0", bus.vblank);
    else passed++;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    wait_for(0, 1'b0, 2000, ok);
    checks++;
    if (!ok || cyc - rel_cyc != 658)
      $display("FAIL first_hsync got %0d (seen=%0d) want 658", cyc - rel_cyc, ok);
    else passed++;
  endtask

  task automatic test_pattern();
    int   ph[8] = '{0, 3, 4, 3, 4, 7, 8, 4};
    int   pv[8] = '{1, 3, 3, 4, 4, 7, 7, 8};
    logic [11:0] pe[8] = '{FG, FG, 12'h000, 12'h000, FG, FG, 12'h000, 12'h000};
    bit ok;
    for (int i = 0; i < 8; i++) begin
      // Pins lag the counters by two cycles.
      wait_pos(ph[i] + 2, pv[i], 10000, ok);
      checks++;
      if (!ok || {bus.vga_r, bus.vga_g, bus.vga_b} !== pe[i])
        $display("FAIL pattern h=%0d v=%0d got %h (seen=%0d) want %h", ph[i], pv[i],
                 {bus.vga_r, bus.vga_g, bus.vga_b}, ok, pe[i]);
      else passed++;
    end
  endtask

  task automatic test_hsync_line();
    bit ok;
    int unsigned t0;
    wait_for(0, 1'b0, 1000, ok);
    t0 = cyc;
    wait_for(0, 1'b1, 1000, ok);
    checks++;
    if (!ok || cyc - t0 != 96) $display("FAIL hsync_width got %0d want 96", cyc - t0);
    else passed++;
    wait_for(0, 1'b0, 1000, ok);
    checks++;
    if (!ok || cyc - t0 != 800) $display("FAIL hsync_period got %0d want 800", cyc - t0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    mem[50 * 160 + 74] = 1'b1;  // lights h 296..299 on v 200..203
    wait_pos(300, 200, 200000, ok);
    checks++;
    if (!ok || {bus.vga_r, bus.vga_g, bus.vga_b} !== FG || bus.read_addr !== AW'(8075))
      $display("FAIL pre_reset got rgb=%h addr=%0d (seen=%0d) want rgb=%h addr=8075",
               {bus.vga_r, bus.vga_g, bus.vga_b}, bus.read_addr, ok, FG);
    else passed++;
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.vga_r, bus.vga_g, bus.vga_b, bus.hsync, bus.vsync, bus.vblank} !==
        {12'h000, 3'b110} || bus.read_addr !== '0)
      $display("FAIL async_reset got rgb=%h hs=%b vs=%b vb=%b addr=%0d want 000 1 1 0 0",
               {bus.vga_r, bus.vga_g, bus.vga_b}, bus.hsync, bus.vsync, bus.vblank,
               bus.read_addr);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_read_addr();
    bit ok;
    wait_pos(639, 479, 400000, ok);
    checks++;
    if (!ok || bus.read_addr !== AW'(19199))
      $display("FAIL addr_last got %0d (seen=%0d) want 19199", bus.read_addr, ok);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.read_addr !== '0) $display("FAIL addr_blank got %0d want 0", bus.read_addr);
    else passed++;
    force_one = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 12'h000)
      $display("FAIL blank_mask got %h want 000", {bus.vga_r, bus.vga_g, bus.vga_b});
    else passed++;
    wait_pos(700, 479, 1000, ok);
    force_one = 1'b0;
  endtask

  task automatic test_vblank_vsync();
    bit ok;
    int unsigned t0;
    int unsigned tv;
    wait_for(2, 1'b1, 5000, ok);
    t0 = cyc;
    checks++;
    if (!ok || t0 - rel_cyc != 480 * 800 + 2)
      $display("FAIL vblank_rise got %0d want %0d", t0 - rel_cyc, 480 * 800 + 2);
    else passed++;
    wait_for(1, 1'b0, 20000, ok);
    tv = cyc;
    checks++;
    if (!ok || tv - rel_cyc != 490 * 800 + 2)
      $display("FAIL vsync_fall got %0d want %0d", tv - rel_cyc, 490 * 800 + 2);
    else passed++;
    wait_for(1, 1'b1, 5000, ok);
    checks++;
    if (!ok || cyc - tv != 1600) $display("FAIL vsync_width got %0d want 1600", cyc - tv);
    else passed++;
    wait_for(2, 1'b0, 40000, ok);
    checks++;
    if (!ok || cyc - t0 != 45 * 800)
      $display("FAIL vblank_width got %0d want %0d", cyc - t0, 45 * 800);
    else passed++;
    checks++;
    if (cyc - rel_cyc != 525 * 800 + 2)
      $display("FAIL vblank_fall got %0d want %0d", cyc - rel_cyc, 525 * 800 + 2);
    else passed++;
    wait_pos(12, 8, 20000, ok);
  endtask

  initial begin
    mem[0]   = 1'b1;
    mem[161] = 1'b1;
    test_reset();
    test_pattern();
    test_hsync_line();
    test_reset_mid();
    test_read_addr();
    test_vblank_vsync();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #(40 * 700000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
